// File: rtl/core_input_driver.sv
// Stimulus source for the 2-bit-input processor core: plays a FIFO of (code, hold)
// entries onto i1/i0, gates the core clock enable and reports the resulting core state.
module core_input_driver #(
    parameter int DEPTH  = 8,
    parameter int HOLD_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              start,
    input  logic              wr_valid,
    input  logic [1:0]        wr_code,
    input  logic [HOLD_W-1:0] wr_hold,
    output logic              wr_ready,
    output logic              i1,
    output logic              i0,
    output logic              core_en,
    input  logic              c1,
    input  logic              c0,
    output logic              obs_valid,
    output logic [1:0]        obs_state,
    output logic              busy,
    output logic              done
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRIVE, SAMPLE} state_e;

    state_e             state_q;
    logic [1:0]         code_mem [DEPTH];
    logic [HOLD_W-1:0]  hold_mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [HOLD_W-1:0]  hold_cnt_q;
    logic [1:0]         code_q;
    logic [1:0]         obs_state_q;
    logic               obs_valid_q;
    logic               done_q;
    logic               push, pop;

    assign wr_ready = (count_q < CNT_W'(DEPTH));
    assign push     = wr_valid && wr_ready;
    assign pop      = (state_q == FETCH);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: storage array carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push) begin
            code_mem[wr_ptr_q] <= wr_code;
            hold_mem[wr_ptr_q] <= wr_hold;
        end
    end

    // Pointers are PTR_W wide, so DEPTH being a power of two makes them wrap for free.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            code_q      <= '0;
            hold_cnt_q  <= '0;
            obs_state_q <= '0;
            obs_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            obs_valid_q <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (count_q != '0) state_q <= FETCH;
                        else               done_q  <= 1'b1;
                    end
                end
                FETCH: begin
                    code_q     <= code_mem[rd_ptr_q];
                    hold_cnt_q <= hold_mem[rd_ptr_q];
                    state_q    <= DRIVE;
                end
                DRIVE: begin
                    if (en) begin
                        if (hold_cnt_q == '0) state_q    <= SAMPLE;
                        else                  hold_cnt_q <= hold_cnt_q - HOLD_W'(1);
                    end
                end
                SAMPLE: begin
                    obs_state_q <= {c1, c0};
                    obs_valid_q <= 1'b1;
                    // Entries pushed before this edge extend the running sequence.
                    if (count_q != '0) begin
                        state_q <= FETCH;
                    end else begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign i1        = code_q[1];
    assign i0        = code_q[0];
    assign core_en   = (state_q == DRIVE) && en;
    assign obs_valid = obs_valid_q;
    assign obs_state = obs_state_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

endmodule
